// File: rtl/led_data_scheduler_pkg.sv
// Shared types and helpers for the LED display scheduler.
// Holds the FSM state type, the display word geometry and a one-hot helper.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    localparam int DIGIT_W = 4;
    localparam int DIGITS  = 4;
    localparam int DATA_W  = DIGIT_W * DIGITS;

    // Sized for the largest supported requester count (8); callers truncate.
    function automatic logic [7:0] one_hot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/led_data_scheduler_rr_pick.sv
// Combinational round-robin picker: finds the first set request after last_idx,
// wrapping, so that last_idx itself is considered last.
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    last_idx,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] w_cand;

    // Walk from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        found  = 1'b0;
        idx    = last_idx;
        w_cand = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            w_cand = IW'((int'(last_idx) + i) % N_SRC);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/led_data_scheduler.sv
// Round-robin time-multiplexer of N_SRC 16-bit display values onto one LED driver.
// Define LED_SCHED_GAP_EN to insert GAP_CYCLES blank cycles between different owners.
module led_data_scheduler
    import led_sched_pkg::*;
#(
    parameter int          N_SRC        = 4,
    parameter int          HOLD_CYCLES  = 1000,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000,
    parameter int          GAP_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      src_req,
    input  logic [N_SRC*16-1:0]   src_data,
    output logic [N_SRC-1:0]      grant,
    output logic [$clog2(N_SRC)-1:0] grant_idx,
    output logic [15:0]           data_out,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int IW = $clog2(N_SRC);
    localparam int TW = $clog2(HOLD_CYCLES);

    sched_state_t      r_state;
    logic [N_SRC-1:0]  r_grant;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic [TW-1:0]     r_timer;
`ifdef LED_SCHED_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]     r_gap_cnt;
`endif

    logic [DATA_W-1:0] w_src [N_SRC];
    logic              w_found;
    logic [IW-1:0]     w_pick;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_src[g] = src_data[16*g +: 16];
    end

    rr_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (
        .req      (src_req),
        .last_idx (r_idx),
        .found    (w_found),
        .idx      (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_idx     <= IW'(N_SRC - 1);
            r_data    <= IDLE_PATTERN;
            r_busy    <= 1'b0;
            r_timer   <= '0;
`ifdef LED_SCHED_GAP_EN
            r_gap_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= SHOW;
                        r_grant <= N_SRC'(one_hot(3'(w_pick)));
                        r_idx   <= w_pick;
                        r_data  <= w_src[w_pick];
                        r_busy  <= 1'b1;
                        r_timer <= TW'(HOLD_CYCLES - 1);
                    end else begin
                        r_data  <= IDLE_PATTERN;
                    end
                end
                SHOW: begin
                    if (r_timer == '0 || !src_req[r_idx]) begin
                        if (!w_found) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_data  <= IDLE_PATTERN;
                        end else if (w_pick == r_idx) begin
                            r_timer <= TW'(HOLD_CYCLES - 1);
                            r_data  <= w_src[r_idx];
                        end else begin
`ifdef LED_SCHED_GAP_EN
                            // grant_idx keeps the old owner so the post-gap pick stays fair.
                            r_state   <= GAP;
                            r_grant   <= '0;
                            r_busy    <= 1'b0;
                            r_data    <= IDLE_PATTERN;
                            r_gap_cnt <= GW'(GAP_CYCLES - 1);
`else
                            r_grant <= N_SRC'(one_hot(3'(w_pick)));
                            r_idx   <= w_pick;
                            r_data  <= w_src[w_pick];
                            r_timer <= TW'(HOLD_CYCLES - 1);
`endif
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        r_data  <= w_src[r_idx];
                    end
                end
`ifdef LED_SCHED_GAP_EN
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        if (w_found) begin
                            r_state <= SHOW;
                            r_grant <= N_SRC'(one_hot(3'(w_pick)));
                            r_idx   <= w_pick;
                            r_data  <= w_src[w_pick];
                            r_busy  <= 1'b1;
                            r_timer <= TW'(HOLD_CYCLES - 1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_data  <= IDLE_PATTERN;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign data_out  = r_data;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_led_data_scheduler.sv
// Self-checking bench for led_data_scheduler (N_SRC=3, HOLD_CYCLES=4, GAP_CYCLES=2).
// An ownership-level reference model predicts every output after each rising edge.
module tb_led_data_scheduler;
  import led_sched_pkg::*;

  localparam int N = 3;
  localparam int HOLD = 4;
  localparam int GAPC = 2;
  localparam logic [15:0] IDLE_P = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] src_req = '0;
  logic [N*16-1:0] src_data = '0;
  logic [N-1:0] grant;
  logic [1:0] grant_idx;
  logic [15:0] data_out;
  logic busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // model: who owns the display, how many cycles it has owned it, gap cycles left
  int m_owner, m_last, m_owned, m_gap;
  logic [N-1:0] e_grant;
  logic [1:0] e_idx;
  logic [15:0] e_data;
  logic e_busy;

  led_data_scheduler #(
    .N_SRC(N), .HOLD_CYCLES(HOLD), .IDLE_PATTERN(IDLE_P), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data),
    .grant(grant), .grant_idx(grant_idx), .data_out(data_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int last, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++) begin
      if (req[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_owned = 0; m_gap = 0;
    e_grant = '0; e_idx = 2'(N - 1); e_data = IDLE_P; e_busy = 1'b0;
  endtask

  task automatic take(input int k);
    m_owner = k; m_last = k; m_owned = 1;
  endtask

  task automatic model_edge();
    int k;
    if (m_gap > 0) begin
      if (m_gap > 1) m_gap--;
      else begin
        m_gap = 0;
        k = pick(m_last, src_req);
        if (k >= 0) take(k);
      end
    end else if (m_owner < 0) begin
      k = pick(m_last, src_req);
      if (k >= 0) take(k);
    end else if (m_owned == HOLD || !src_req[m_owner]) begin
      k = pick(m_last, src_req);
      if (k < 0) m_owner = -1;
      else if (k == m_owner) m_owned = 1;
      else begin
`ifdef LED_SCHED_GAP_EN
        m_owner = -1; m_gap = GAPC;
`else
        take(k);
`endif
      end
    end else begin
      m_owned++;
    end
    e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_idx   = 2'(m_last);
    e_data  = (m_owner >= 0) ? src_data[16*m_owner +: 16] : IDLE_P;
    e_busy  = (m_owner >= 0);
  endtask

  // advance one rising edge, update the model, and settle before sampling
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_data(input int s, input logic [15:0] v);
    src_data[16*s +: 16] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_req = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, grant_idx, data_out, busy} !== {3'b000, 2'd2, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: grant=%b idx=%0d data=%h busy=%b, required 000/2/0000/0", grant, grant_idx, data_out, busy);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, IDLE);
    end
    repeat (3) begin
      step();
      n_checks++;
      if ({grant, grant_idx, data_out, busy} !== {3'b000, 2'd2, 16'h0000, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_hold: grant=%b idx=%0d data=%h busy=%b, required 000/2/0000/0", grant, grant_idx, data_out, busy);
      end
    end
  endtask

  task automatic test_single();
    set_data(1, 16'h8787);
    src_req = 3'b010;
    step();
    n_checks++;
    if ({grant, data_out, busy} !== {3'b010, 16'h8787, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b data=%h busy=%b, required 010/8787/1", grant, data_out, busy);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 5) set_data(1, 16'h06ae);
      step();
      n_checks++;
      if ({grant, grant_idx, data_out, busy} !== {e_grant, e_idx, e_data, e_busy} || grant !== 3'b010) begin
        n_fail++;
        $display("FAIL single_hold c%0d: grant=%b idx=%0d data=%h busy=%b, required %b/%0d/%h/%b", c, grant, grant_idx, data_out, busy, e_grant, e_idx, e_data, e_busy);
      end
      if (c == 5) begin
        n_checks++;
        if (data_out !== 16'h06ae) begin
          n_fail++;
          $display("FAIL live_update: data=%h required 06ae", data_out);
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g [16];
    do_reset();
    set_data(0, 16'h1111); set_data(1, 16'h2222); set_data(2, 16'h3333);
    src_req = 3'b111;
    for (int c = 0; c < 16; c++) exp_g[c] = N'(1 << ((c / 4) % 3));
    for (int c = 0; c < 16; c++) begin
      step();
      n_checks++;
      if (grant !== exp_g[c] || data_out !== e_data || grant !== e_grant) begin
        n_fail++;
        $display("FAIL rotation c%0d: grant=%b data=%h, required %b/%h", c, grant, data_out, exp_g[c], e_data);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    src_req = 3'b101;
    step(); step();
    src_req = 3'b100;
    step();
    n_checks++;
    if (grant !== 3'b100 || grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL early_release: grant=%b idx=%0d required 100/2", grant, grant_idx);
    end
    step();
    src_req = 3'b000;
    step();
    n_checks++;
    if ({grant, data_out, busy} !== {3'b000, 16'h0000, 1'b0} || grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL release_idle: grant=%b idx=%0d data=%h busy=%b required 000/2/0000/0", grant, grant_idx, data_out, busy);
    end
  endtask

  task automatic test_reset_mid_hold();
    src_req = 3'b111;
    step(); step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({grant, data_out, busy} !== {3'b000, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: grant=%b data=%h busy=%b required 000/0000/0", grant, data_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if (grant !== 3'b001 || data_out !== 16'h1111) begin
      n_fail++;
      $display("FAIL post_reset_first: grant=%b data=%h required 001/1111", grant, data_out);
    end
  endtask

  task automatic test_owner_switch();
`ifdef LED_SCHED_GAP_EN
    logic [N-1:0] exp_g [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010};
`else
    logic [N-1:0] exp_g [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
`endif
    do_reset();
    src_req = 3'b011;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (grant !== exp_g[c] || busy !== (exp_g[c] != 0) || (exp_g[c] == 0 && data_out !== IDLE_P)) begin
        n_fail++;
        $display("FAIL owner_switch c%0d: grant=%b busy=%b data=%h required grant %b", c, grant, busy, data_out, exp_g[c]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) src_req = N'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) set_data($urandom_range(0, N - 1), 16'($urandom));
      step();
      n_checks++;
      if ({grant, grant_idx, data_out, busy} !== {e_grant, e_idx, e_data, e_busy}) begin
        n_fail++;
        $display("FAIL random c%0d: grant=%b idx=%0d data=%h busy=%b, required %b/%0d/%h/%b", c, grant, grant_idx, data_out, busy, e_grant, e_idx, e_data, e_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_reset_mid_hold();
    test_owner_switch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
